vu_tap_scheduler: RTL
=====================

// Module: vu_tap_scheduler
// PURPOSE
//  Time-shares the single stereo VU meter between NUM_TAPS audio taps (e.g. ADC in, post-FX, DAC out).
//  Routes one tap's samples to the meter and steps through taps on a dwell timer (auto) or holds a user-selected tap (manual).
//  On each tap change it pulses a meter peak-clear, then blanks the meter so stale peaks never show against the new tap.
//  Sits between the audio datapath taps and the VU meter; drives the tap indicator on the front panel.
// PARAMETERS
//  NUM_TAPS      4          number of stereo taps; 2..8
//  DWELL_CYCLES  50000000   clocks per tap in auto-scan (1 s at 50 MHz); >=2
//  BLANK_CYCLES  500000     clocks meter_valid is held low after a clear (10 ms); 0 allowed
//  CLIP_LEVEL    32'h7F000000  magnitude at or above which a tap sample counts as clipped
// PORTS
//  clock        in   1            system clock, 50 MHz
//  reset        in   1            asynchronous, active-high
//  enable       in   1            0 = meter idle
//  auto_scan    in   1            1 = rotate taps on dwell timer, 0 = manual_sel
//  manual_sel   in   3            requested tap in manual mode
//  tap_L        in   NUM_TAPS*32  signed left samples, tap i at [32i+31:32i]
//  tap_R        in   NUM_TAPS*32  signed right samples, same packing
//  tap_valid    in   NUM_TAPS     per-tap sample strobe
//  meter_L      out  32           selected left sample, registered
//  meter_R      out  32           selected right sample, registered
//  meter_valid  out  1            sample strobe to the meter
//  meter_clear  out  1            one-cycle peak-clear pulse to the meter
//  active_tap   out  3            tap currently routed
//  clip_flags   out  NUM_TAPS     sticky per-tap clip flags (see CONFIGURATION)
//  clip_clear   in   1            clears all clip_flags
// BEHAVIOUR
//  Reset: state IDLE; meter_L/R=0, meter_valid=0, meter_clear=0, active_tap=0, clip_flags=0, dwell/blank counters=0.
//  FSM IDLE -> CLEAR -> BLANK -> RUN -> (CLEAR on switch). Outputs are registered.
//  IDLE: meter_valid=0. enable=1 -> CLEAR with next_tap=active_tap.
//  CLEAR (1 cycle): active_tap<=next_tap, meter_clear=1, meter_valid=0. -> BLANK, or -> RUN if BLANK_CYCLES=0.
//  BLANK: count BLANK_CYCLES clocks with meter_valid=0, then -> RUN. Tap requests made in CLEAR/BLANK are not lost:
//    they are evaluated on the first RUN cycle.
//  RUN: meter_L/R<=tap[active_tap], meter_valid<=tap_valid[active_tap]. Latency 1 clock from tap_valid.
//    Dwell counter is cleared on RUN entry and counts only while auto_scan=1; it is held at 0 while auto_scan=0.
//    auto_scan=1 and counter = DWELL_CYCLES-1 -> next_tap=(active_tap+1) mod NUM_TAPS, -> CLEAR.
//    auto_scan=0 and manual_sel!=active_tap and manual_sel<NUM_TAPS -> next_tap=manual_sel, -> CLEAR.
//    manual_sel>=NUM_TAPS is ignored: stay on the current tap.
//  enable=0 in any state -> IDLE next cycle. meter_valid and meter_clear go 0 in that same cycle. active_tap is kept.
//  Asynchronous reset mid-sequence (CLEAR/BLANK): all state returns to reset values at once. No pending clear is replayed.
// CONFIGURATION
//  Macro VU_CLIP_LATCH_EN. Defined: clip detection runs on all taps in parallel, whether or not the tap is selected.
//    |L| or |R| >= CLIP_LEVEL with tap_valid[i]=1 sets clip_flags[i] on the next clock.
//    clip_clear=1 clears all flags. On a set and a clear in the same cycle, the set wins.
//    Magnitude of 32'h80000000 is treated as 32'h7FFFFFFF (saturating abs).
//  Not defined: clip_flags is tied to 0 and clip_clear is ignored; no clip logic is synthesized.
// STRUCTURE
//  Package vu_pkg: sched_state_e {IDLE,CLEAR,BLANK,RUN}; typedef logic signed [31:0] sample_t; TAP_SEL_W=3.
//  Sub-module vu_clip_detect (saturating abs, compare, sticky flag), instantiated per tap in a generate loop under VU_CLIP_LATCH_EN.
// TESTING (bench uses NUM_TAPS=4, DWELL_CYCLES=16, BLANK_CYCLES=4)
//  1. Reset, enable=1, auto_scan=1 -> meter_clear for 1 cycle, meter_valid=0 for 4 cycles, then active_tap
//     goes 0,1,2,3,0 with a CLEAR+BLANK between each tap.
//  2. RUN on tap 2, tap_valid[2]=1 with tap_L=32'h00123456 -> meter_L=32'h00123456, meter_valid=1 one clock later;
//     tap_valid[1] pulses -> no meter_valid.
//  3. auto_scan=0, manual_sel=3 while in BLANK -> BLANK completes, one RUN cycle, CLEAR, active_tap=3;
//     manual_sel=5 -> no change.
//  4. BLANK_CYCLES=0 build -> CLEAR goes directly to RUN. enable=0 during BLANK -> IDLE next cycle,
//     meter_valid=0, active_tap kept.
//  5. VU_CLIP_LATCH_EN: tap 1 unselected, tap_R=32'h80000000 valid -> clip_flags=4'b0010.
//     clip_clear with a new clip on tap 1 in the same cycle -> flag stays 1.
//  6. Reset asserted mid-CLEAR -> all outputs 0 asynchronously. Without the macro, clip_flags stays 0 under full-scale input.

Source files
------------

// File: rtl/vu_tap_scheduler_pkg.sv
// Shared types for the VU tap scheduler: FSM state encoding, sample type and
// the saturating magnitude helper used by the clip detectors.
package vu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    BLANK = 2'd2,
    RUN   = 2'd3
  } sched_state_e;

  typedef logic signed [31:0] sample_t;

  localparam int TAP_SEL_W = 3;
  localparam int MAX_TAPS  = 1 << TAP_SEL_W;

  // -2^31 has no positive twin, so it saturates to the largest positive value.
  function automatic logic [31:0] sat_abs(input sample_t s);
    if (s == 32'sh8000_0000) return 32'h7FFF_FFFF;
    else if (s < 0)          return 32'(-s);
    else                     return 32'(s);
  endfunction

endpackage

// File: rtl/vu_tap_scheduler_clip_detect.sv
// Per-tap sticky clip flag: set when either channel's magnitude reaches
// CLIP_LEVEL on a valid sample; a set beats a simultaneous clear.
module vu_clip_detect
  import vu_pkg::*;
#(
  parameter logic [31:0] CLIP_LEVEL = 32'h7F00_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_sample_l,
  input  logic [31:0] i_sample_r,
  input  logic        i_valid,
  input  logic        i_clear,
  output logic        o_flag
);

  logic [31:0] w_mag_l;
  logic [31:0] w_mag_r;
  logic        w_hit;
  logic        r_flag;

  assign w_mag_l = sat_abs(i_sample_l);
  assign w_mag_r = sat_abs(i_sample_r);
  assign w_hit   = i_valid && ((w_mag_l >= CLIP_LEVEL) || (w_mag_r >= CLIP_LEVEL));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_flag <= 1'b0;
    else if (w_hit)   r_flag <= 1'b1;
    else if (i_clear) r_flag <= 1'b0;
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/vu_tap_scheduler.sv
// Time-shares one stereo VU meter across NUM_TAPS taps with a clear/blank gap on
// every tap change. Define VU_CLIP_LATCH_EN to build the per-tap sticky clip flags.
module vu_tap_scheduler
  import vu_pkg::*;
#(
  parameter int          NUM_TAPS     = 4,
  parameter int          DWELL_CYCLES = 50000000,
  parameter int          BLANK_CYCLES = 500000,
  parameter logic [31:0] CLIP_LEVEL   = 32'h7F00_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_auto_scan,
  input  logic [2:0]            i_manual_sel,
  input  logic [NUM_TAPS*32-1:0] i_tap_l,
  input  logic [NUM_TAPS*32-1:0] i_tap_r,
  input  logic [NUM_TAPS-1:0]   i_tap_valid,
  input  logic                  i_clip_clear,
  output logic [31:0]           o_meter_l,
  output logic [31:0]           o_meter_r,
  output logic                  o_meter_valid,
  output logic                  o_meter_clear,
  output logic [2:0]            o_active_tap,
  output logic [NUM_TAPS-1:0]   o_clip_flags,
  output logic [1:0]            o_state
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [2:0]    TAP_LAST   = 3'(NUM_TAPS - 1);

  sched_state_e r_state, w_state_nxt;
  logic [2:0]    r_active_tap, r_next_tap, w_tap_nxt;
  logic [DW-1:0] r_dwell_cnt;
  logic [BW-1:0] r_blank_cnt;
  logic [31:0]   r_meter_l, r_meter_r;
  logic          r_meter_valid, r_meter_clear;
  logic          w_sel_ok;

  // Padded to the full select range so the 3-bit tap index never overruns.
  logic [31:0]         w_tap_l [MAX_TAPS];
  logic [31:0]         w_tap_r [MAX_TAPS];
  logic [MAX_TAPS-1:0] w_tap_valid;

  for (genvar g = 0; g < MAX_TAPS; g++) begin : g_tap
    if (g < NUM_TAPS) begin : g_used
      assign w_tap_l[g]     = i_tap_l[g*32 +: 32];
      assign w_tap_r[g]     = i_tap_r[g*32 +: 32];
      assign w_tap_valid[g] = i_tap_valid[g];
    end else begin : g_pad
      assign w_tap_l[g]     = '0;
      assign w_tap_r[g]     = '0;
      assign w_tap_valid[g] = 1'b0;
    end
  end

  assign w_sel_ok = ({29'd0, i_manual_sel} < 32'(NUM_TAPS));

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_next_tap;
    case (r_state)
      IDLE: if (i_enable) begin
        w_state_nxt = CLEAR;
        w_tap_nxt   = r_active_tap;
      end
      CLEAR: w_state_nxt = (BLANK_CYCLES == 0) ? RUN : BLANK;
      BLANK: if (r_blank_cnt == BLANK_LAST) w_state_nxt = RUN;
      RUN: begin
        if (i_auto_scan) begin
          if (r_dwell_cnt == DWELL_LAST) begin
            w_tap_nxt   = (r_active_tap == TAP_LAST) ? 3'd0 : r_active_tap + 3'd1;
            w_state_nxt = CLEAR;
          end
        end else if ((i_manual_sel != r_active_tap) && w_sel_ok) begin
          w_tap_nxt   = i_manual_sel;
          w_state_nxt = CLEAR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!i_enable) w_state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_active_tap  <= '0;
      r_next_tap    <= '0;
      r_dwell_cnt   <= '0;
      r_blank_cnt   <= '0;
      r_meter_l     <= '0;
      r_meter_r     <= '0;
      r_meter_valid <= 1'b0;
      r_meter_clear <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_next_tap    <= w_tap_nxt;
      r_meter_clear <= (w_state_nxt == CLEAR);
      // A sample is only forwarded while RUN continues, so nothing leaks into CLEAR/IDLE.
      r_meter_valid <= (r_state == RUN && w_state_nxt == RUN) ? w_tap_valid[r_active_tap] : 1'b0;
      if (r_state == CLEAR && i_enable) r_active_tap <= r_next_tap;
      if (r_state == RUN) begin
        r_meter_l <= w_tap_l[r_active_tap];
        r_meter_r <= w_tap_r[r_active_tap];
      end
      r_blank_cnt <= (r_state == BLANK) ? r_blank_cnt + 1'b1 : '0;
      if (r_state == RUN && w_state_nxt == RUN && i_auto_scan) r_dwell_cnt <= r_dwell_cnt + 1'b1;
      else                                                      r_dwell_cnt <= '0;
    end
  end

`ifdef VU_CLIP_LATCH_EN
  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_clip
    vu_clip_detect #(.CLIP_LEVEL(CLIP_LEVEL)) u_clip (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_sample_l (i_tap_l[t*32 +: 32]),
      .i_sample_r (i_tap_r[t*32 +: 32]),
      .i_valid    (i_tap_valid[t]),
      .i_clear    (i_clip_clear),
      .o_flag     (o_clip_flags[t])
    );
  end
`else
  logic w_unused_clip_clear;
  assign w_unused_clip_clear = i_clip_clear;
  assign o_clip_flags = '0;
`endif

  assign o_meter_l     = r_meter_l;
  assign o_meter_r     = r_meter_r;
  assign o_meter_valid = r_meter_valid;
  assign o_meter_clear = r_meter_clear;
  assign o_active_tap  = r_active_tap;
  assign o_state       = r_state;

endmodule
